// File: rtl/count_frame_tx_pkg.sv
// Shared definitions for the counter frame transmitter: FSM state encoding and
// the default frame header byte.
package count_frame_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/count_frame_tx_byte_sel.sv
// Picks data byte idx out of the concatenated snapshots {snap0, snap1},
// most significant byte of snap0 first.
module count_byte_sel #(
    parameter int WIDTH = 64,
    parameter int IDXW  = $clog2(2 * (WIDTH / 8))
) (
    input  logic [WIDTH-1:0] snap0,
    input  logic [WIDTH-1:0] snap1,
    input  logic [IDXW-1:0]  idx,
    output logic [7:0]       byte_out
);

    localparam int NDATA = 2 * (WIDTH / 8);

    logic [2*WIDTH-1:0] cat;

    assign cat = {snap0, snap1};

    always_comb begin
        byte_out = '0;
        for (int i = 0; i < NDATA; i++) begin
            if (idx == IDXW'(i)) begin
                byte_out = cat[(NDATA-1-i)*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/count_frame_tx.sv
// Snapshots two counter values on request and streams them out as a framed,
// checksummed byte sequence over a valid/ready handshake.
module count_frame_tx
    import count_frame_tx_pkg::*;
#(
    parameter int         WIDTH  = 64,
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In0,
    input  logic [WIDTH-1:0] In1,
    input  logic             Req,
    output logic [7:0]       Dout,
    output logic             Dvalid,
    input  logic             Dready,
    output logic             Busy,
    output logic [7:0]       DropCnt
);

    localparam int NBYTES = WIDTH / 8;
    localparam int NDATA  = 2 * NBYTES;
    localparam int IDXW   = $clog2(NDATA);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDATA - 1);

    state_t            state, state_n;
    logic [IDXW-1:0]   idx, idx_n;
    logic              pending, pending_n;
    logic [7:0]        drop_cnt, drop_n;
    logic [WIDTH-1:0]  snap0, snap1;
    logic              snap_load;
    logic              accept;
    logic [7:0]        data_byte;
    logic [7:0]        csum;

    count_byte_sel #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_byte_sel (
        .snap0    (snap0),
        .snap1    (snap1),
        .idx      (idx),
        .byte_out (data_byte)
    );

    always_comb begin
        csum = '0;
        for (int i = 0; i < NBYTES; i++) begin
            csum = csum ^ snap0[i*8 +: 8] ^ snap1[i*8 +: 8];
        end
    end

    assign Busy    = (state != S_IDLE);
    assign Dvalid  = Busy;
    assign DropCnt = drop_cnt;
    assign accept  = Dvalid && Dready;

    always_comb begin
        unique case (state)
            S_HDR:   Dout = HEADER;
            S_DATA:  Dout = data_byte;
            S_CSUM:  Dout = csum;
            default: Dout = '0;
        endcase
    end

    // A request that lands on the final CSUM edge with no slot queued is parked in
    // pending; IDLE picks it up so that request is never stranded.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        pending_n = pending;
        drop_n    = drop_cnt;
        snap_load = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (Req || pending) begin
                    snap_load = 1'b1;
                    pending_n = 1'b0;
                    state_n   = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    idx_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = S_CSUM;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (pending) begin
                        pending_n = 1'b0;
                        snap_load = 1'b1;
                        state_n   = S_HDR;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (Req && Busy) begin
            if (!pending) begin
                pending_n = 1'b1;
            end else if (drop_cnt != 8'hFF) begin
                drop_n = drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            pending  <= 1'b0;
            drop_cnt <= '0;
            snap0    <= '0;
            snap1    <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            pending  <= pending_n;
            drop_cnt <= drop_n;
            if (snap_load) begin
                snap0 <= In0;
                snap1 <= In1;
            end
        end
    end

endmodule

// File: tb/tb_count_frame_tx.sv
// Directed self-checking bench for count_frame_tx: frame content, stalls,
// snapshot isolation, overrun queuing/dropping and mid-frame reset.
module tb_count_frame_tx;

    typedef logic [7:0] frame_t [18];

    logic        Clk;
    logic        Reset;
    logic [63:0] In0;
    logic [63:0] In1;
    logic        Req;
    logic [7:0]  Dout;
    logic        Dvalid;
    logic        Dready;
    logic        Busy;
    logic [7:0]  DropCnt;

    int errors = 0;
    int checks = 0;

    count_frame_tx #(
        .WIDTH  (64),
        .HEADER (8'hA5)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .In0     (In0),
        .In1     (In1),
        .Req     (Req),
        .Dout    (Dout),
        .Dvalid  (Dvalid),
        .Dready  (Dready),
        .Busy    (Busy),
        .DropCnt (DropCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference frame: header, In0 MSB first, In1 MSB first, XOR of the data bytes.
    function automatic frame_t make_frame(input logic [63:0] a, input logic [63:0] b);
        frame_t     f;
        logic [7:0] c;
        c    = 8'h00;
        f[0] = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            f[1+i] = a[63-8*i -: 8];
            f[9+i] = b[63-8*i -: 8];
            c      = c ^ a[63-8*i -: 8] ^ b[63-8*i -: 8];
        end
        f[17] = c;
        return f;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset  = 1'b0;
        Req    = 1'b0;
        Dready = 1'b1;
        tick();
        tick();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset  = 1'b0;
        Req    = 1'b0;
        Dready = 1'b1;
        In0    = '0;
        In1    = '0;
        tick();
        tick();
        checks++;
        if (Dvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dvalid got=%0b exp=0", Dvalid);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy got=%0b exp=0", Busy);
        end
        checks++;
        if (Dout !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_dout got=%h exp=00", Dout);
        end
        checks++;
        if (DropCnt !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_dropcnt got=%h exp=00", DropCnt);
        end
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame();
        frame_t exp;
        exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h06};
        do_reset();
        In0    = 64'h102;
        In1    = 64'h5;
        Dready = 1'b1;
        Req    = 1'b1;
        tick();
        Req = 1'b0;
        for (int k = 0; k < 18; k++) begin
            checks++;
            if (Dvalid !== 1'b1 || Dout !== exp[k]) begin
                errors++;
                $display("[TB] FAIL basic_byte%0d got valid=%0b dout=%h exp valid=1 dout=%h",
                         k, Dvalid, Dout, exp[k]);
            end
            tick();
        end
        checks++;
        if (Busy !== 1'b0 || Dvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_idle got busy=%0b valid=%0b exp 0/0", Busy, Dvalid);
        end
    endtask

    task automatic test_stall();
        frame_t exp;
        int     k;
        int     c;
        exp = make_frame(64'h102, 64'h5);
        do_reset();
        In0    = 64'h102;
        In1    = 64'h5;
        Req    = 1'b1;
        tick();
        Req = 1'b0;
        k   = 0;
        c   = 0;
        while (k < 18 && c < 200) begin
            checks++;
            if (Dvalid !== 1'b1 || Dout !== exp[k]) begin
                errors++;
                $display("[TB] FAIL stall_byte%0d cyc%0d got valid=%0b dout=%h exp valid=1 dout=%h",
                         k, c, Dvalid, Dout, exp[k]);
            end
            Dready = (c % 2 == 0);
            tick();
            if (Dready) k++;
            c++;
        end
        checks++;
        if (k != 18) begin
            errors++;
            $display("[TB] FAIL stall_timeout got bytes=%0d exp=18", k);
        end
        Dready = 1'b1;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_idle got busy=%0b exp=0", Busy);
        end
    endtask

    task automatic test_snapshot();
        frame_t exp;
        exp = make_frame(64'h102, 64'h5);
        do_reset();
        In0 = 64'h102;
        In1 = 64'h5;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k == 3) In0 = 64'hFFFF;
            checks++;
            if (Dvalid !== 1'b1 || Dout !== exp[k]) begin
                errors++;
                $display("[TB] FAIL snap_byte%0d got valid=%0b dout=%h exp valid=1 dout=%h",
                         k, Dvalid, Dout, exp[k]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        frame_t exp1;
        frame_t exp2;
        exp1 = make_frame(64'h102, 64'h5);
        exp2 = make_frame(64'h1122334455667788, 64'h0);
        do_reset();
        In0 = 64'h102;
        In1 = 64'h5;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        for (int k = 0; k < 18; k++) begin
            checks++;
            if (Dvalid !== 1'b1 || Dout !== exp1[k]) begin
                errors++;
                $display("[TB] FAIL b2b_f1_byte%0d got valid=%0b dout=%h exp valid=1 dout=%h",
                         k, Dvalid, Dout, exp1[k]);
            end
            if (k == 3 || k == 6) Req = 1'b1;
            if (k == 10) begin
                In0 = 64'h1122334455667788;
                In1 = 64'h0;
            end
            tick();
            Req = 1'b0;
        end
        for (int k = 0; k < 18; k++) begin
            checks++;
            if (Dvalid !== 1'b1 || Dout !== exp2[k]) begin
                errors++;
                $display("[TB] FAIL b2b_f2_byte%0d got valid=%0b dout=%h exp valid=1 dout=%h",
                         k, Dvalid, Dout, exp2[k]);
            end
            tick();
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle got busy=%0b exp=0", Busy);
        end
        checks++;
        if (DropCnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL b2b_dropcnt got=%0d exp=1", DropCnt);
        end
    endtask

    task automatic test_reset_midframe();
        frame_t exp1;
        frame_t exp2;
        exp1 = make_frame(64'h102, 64'h5);
        exp2 = make_frame(64'hDEADBEEF00000001, 64'hFF);
        do_reset();
        In0 = 64'h102;
        In1 = 64'h5;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 2 || k == 4) Req = 1'b1;
            tick();
            Req = 1'b0;
        end
        checks++;
        if (Dout !== exp1[7] || DropCnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL midrst_pre got dout=%h drop=%0d exp dout=%h drop=1",
                     Dout, DropCnt, exp1[7]);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if (Dvalid !== 1'b0 || Busy !== 1'b0 || DropCnt !== 8'd0 || Dout !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midrst_clear got valid=%0b busy=%0b drop=%0d dout=%h exp 0/0/0/00",
                     Dvalid, Busy, DropCnt, Dout);
        end
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_no_pending got busy=%0b exp=0", Busy);
        end
        In0 = 64'hDEADBEEF00000001;
        In1 = 64'hFF;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        for (int k = 0; k < 18; k++) begin
            checks++;
            if (Dvalid !== 1'b1 || Dout !== exp2[k]) begin
                errors++;
                $display("[TB] FAIL midrst_fresh_byte%0d got valid=%0b dout=%h exp valid=1 dout=%h",
                         k, Dvalid, Dout, exp2[k]);
            end
            tick();
        end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        Dready = 1'b0;
        In0    = 64'h102;
        In1    = 64'h5;
        Req    = 1'b1;
        tick();
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 10) begin
                checks++;
                if (DropCnt !== 8'd9) begin
                    errors++;
                    $display("[TB] FAIL drop_partial got=%0d exp=9", DropCnt);
                end
            end
        end
        Req = 1'b0;
        checks++;
        if (DropCnt !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL drop_saturate got=%h exp=ff", DropCnt);
        end
        checks++;
        if (Dvalid !== 1'b1 || Dout !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL drop_hold got valid=%0b dout=%h exp valid=1 dout=a5", Dvalid, Dout);
        end
        Dready = 1'b1;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_snapshot();
        test_back_to_back();
        test_reset_midframe();
        test_drop_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
